i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- Responder end of the team's I2C bus: a 7-bit-addressed target that answers the in-house I2C controller or any standard controller.
- Oversamples SCL/SDA on the 100 MHz system clock, detects START/STOP, matches its address and ACKs.
- Write transfers deliver bytes to user logic through a valid strobe. Read transfers fetch bytes through a request strobe.
- No clock stretching: the block never drives SCL.

Parameters:
- TARGET_ADDR, 7'h42, 7-bit address this target answers to.
- FILTER_CYCLES, 3, consecutive equal samples required before a filtered SCL/SDA level changes (glitch rejection).

Ports:
- clk  input  1  system clock, 100 MHz; must be ≥ 20× the SCL frequency.
- rst_n  input  1  asynchronous active-low reset.
- I2C_SCL  input  1  bus clock from the controller; sampled only.
- I2C_SDA_t  inout  1  bus data; driven 0 when sda_drive_low=1, otherwise high-Z.
- tx_data  input  8  byte to return on a read; sampled in the cycle tx_req=1.
- rx_data  output  8  last byte written by the controller.
- rx_valid  output  1  one-cycle pulse; rx_data is new.
- tx_req  output  1  one-cycle pulse; the target samples tx_data this cycle.
- rw  output  1  R/W bit of the current addressed transfer (1 = read).
- busy  output  1  high from a matching address byte until STOP, NACK-end or a non-matching repeated START.

Behaviour:
- Reset (async assert, sync deassert): state IDLE, SDA released, rx_data=0, rx_valid=0, tx_req=0, rw=0, busy=0. Reset mid-transfer releases SDA immediately.
- Input path: 2-flop synchronizer, then FILTER_CYCLES filter, then one-cycle edge pulses scl_rise, scl_fall, sda_rise, sda_fall. Latency is 2+FILTER_CYCLES clks.
- START = sda_fall while filtered SCL=1. STOP = sda_rise while filtered SCL=1. Both are evaluated before data events in the same cycle.
- START in any state: release SDA, clear bit counter, go to ADDR. This covers repeated START.
- STOP in any state: release SDA, busy=0, go to IDLE.
- States: IDLE, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, WAIT_STOP.
- ADDR:
  - Shift SDA in MSB first on each scl_rise.
  - After the 8th rise, compare byte[7:1] with TARGET_ADDR.
  - Match: latch rw=byte[0], busy=1. On the next scl_fall drive SDA low and go to ADDR_ACK.
  - Mismatch: busy=0, go to WAIT_STOP; SDA is never driven.
- ADDR_ACK:
  - rw=0: at the next scl_fall release SDA and go to WRITE.
  - rw=1: pulse tx_req on the scl_rise of the ACK bit and load the shifter. At the next scl_fall drive bit7 (low if 0, released if 1) and go to READ.
- WRITE:
  - Sample 8 bits on scl_rise.
  - On the 8th rise: rx_data <= byte, rx_valid pulses one clk.
  - On the next scl_fall drive ACK and go to WR_ACK.
- WR_ACK: on the next scl_fall release SDA and go to WRITE. Unlimited byte count.
- READ:
  - Drive the next bit on each scl_fall.
  - At the scl_fall after bit0, release SDA and go to RD_ACK.
- RD_ACK: sample SDA on scl_rise.
  - 0 (ACK): tx_req pulses and the shifter loads. Bit7 is driven at the next scl_fall; go to READ.
  - 1 (NACK): busy=0, go to WAIT_STOP.
- WAIT_STOP: SDA released; only START or STOP is acted on.
- SDA only changes in response to scl_fall (or START/STOP/reset), never while filtered SCL=1.
- rx_valid and tx_req are never high in the same cycle.

Decomposition:
- Package i2c_pkg holds:
  - typedef enum logic [2:0] i2c_target_state_t (the eight states above).
  - Constant I2C_RW_READ=1'b1.
  - Constant I2C_ACK=1'b0.
- Sub-module i2c_line_filter does synchronize, filter and edge-detect (params FILTER_CYCLES; outputs level, rise, fall). It is instantiated once for SCL and once for SDA.

Test Plan:
- Write at 100 kHz: addr 0x42/W, data 0xA5, 0x3C, STOP → SDA low in 3 ACK slots; rx_valid pulses twice with rx_data 0xA5 then 0x3C; busy 1→0 after STOP.
- Address 0x43/W, data 0x11 → SDA never driven (NACK seen by controller); no rx_valid; busy stays 0.
- Read at 400 kHz: addr 0x42/R, tx_data 0x81 then 0x7E, controller ACKs byte 1 and NACKs byte 2 → bus shows 0x81, 0x7E; exactly 2 tx_req pulses; SDA released after the NACK; busy=0.
- Write 0x05, repeated START, read 1 byte with tx_data 0xC3 → rx_data=0x05; rw goes 0→1; 0xC3 on the bus; ends released.
- 2-clk glitch on SCL mid-byte during a write of 0x5A → ignored; rx_data=0x5A.
- rst_n asserted while the target drives a 0 bit in READ → SDA high-Z in the same cycle; all outputs at reset values; next START with addr 0x42 is ACKed normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WRITE     = 3'd3,
        ST_WR_ACK    = 3'd4,
        ST_READ      = 3'd5,
        ST_RD_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_target_state_t;

    localparam logic I2C_RW_READ = 1'b1;
    localparam logic I2C_ACK     = 1'b0;

endpackage

// File: rtl/i2c_target_if.sv
// User-side interface of the I2C target.
// Handshake: rx_valid and tx_req are single-cycle strobes with no backpressure.
// rx_data is valid in the cycle rx_valid=1 and holds until the next write byte.
// tx_data must be valid in the cycle tx_req=1; it is captured at the end of that cycle.
interface i2c_target_if;
    import i2c_pkg::*;

    logic [7:0]        tx_data;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              tx_req;
    logic              rw;
    logic              busy;
    i2c_target_state_t state;

    modport slave  (input tx_data, output rx_data, rx_valid, tx_req, rw, busy, state);
    modport master (output tx_data, input rx_data, rx_valid, tx_req, rw, busy, state);
endinterface

// File: rtl/i2c_line_filter.sv
// Synchronizes one bus line, rejects glitches shorter than FILTER_CYCLES
// clocks and produces single-cycle rise/fall pulses aligned with level.
module i2c_line_filter #(
    parameter int FILTER_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer followed by a consecutive-sample counter; the
    // bus idles high so everything resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], line_in};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
                level <= sync[1];
                rise  <= sync[1];
                fall  <= ~sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/i2c_target.sv
// 7-bit addressed I2C target. Never drives SCL; SDA is open-drain.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR   = 7'h42,
    parameter int         FILTER_CYCLES = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          I2C_SCL,
    inout  wire           I2C_SDA_t,
    i2c_target_if.slave   usr
);
    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl_filt (
        .clk(clk), .rst_n(rst_n), .line_in(I2C_SCL),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda_filt (
        .clk(clk), .rst_n(rst_n), .line_in(I2C_SDA_t),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    i2c_target_state_t state;
    logic [3:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              sda_low;
    logic [7:0]        rx_data_q;
    logic              rx_valid_q;
    logic              tx_req_q;
    logic              rw_q;
    logic              busy_q;

    logic       start_cond;
    logic       stop_cond;
    logic [7:0] byte_in;

    // Marks the controller's ACK seen in RD_ACK, waiting for the next SCL fall.
    localparam logic [3:0] CNT_ACKED = 4'd9;

    assign start_cond = sda_fall & scl_lvl;
    assign stop_cond  = sda_rise & scl_lvl;
    assign byte_in    = {shreg[6:0], sda_lvl};

    assign I2C_SDA_t    = sda_low ? 1'b0 : 1'bz;
    assign usr.rx_data  = rx_data_q;
    assign usr.rx_valid = rx_valid_q;
    assign usr.tx_req   = tx_req_q;
    assign usr.rw       = rw_q;
    assign usr.busy     = busy_q;
    assign usr.state    = state;

    // Protocol FSM: START/STOP take priority over bit-level events; SDA
    // only changes on a filtered SCL fall, START/STOP or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            sda_low    <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            if (start_cond) begin
                sda_low <= 1'b0;
                bit_cnt <= '0;
                state   <= ST_ADDR;
            end else if (stop_cond) begin
                sda_low <= 1'b0;
                busy_q  <= 1'b0;
                state   <= ST_IDLE;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shreg   <= byte_in;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if (byte_in[7:1] == TARGET_ADDR) begin
                                    rw_q   <= byte_in[0];
                                    busy_q <= 1'b1;
                                end else begin
                                    busy_q <= 1'b0;
                                    state  <= ST_WAIT_STOP;
                                end
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_low <= 1'b1;
                            state   <= ST_ADDR_ACK;
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (rw_q == I2C_RW_READ) begin
                            if (scl_rise) begin
                                tx_req_q <= 1'b1;
                            end else if (tx_req_q) begin
                                shreg <= usr.tx_data;
                            end else if (scl_fall) begin
                                sda_low <= ~shreg[7];
                                shreg   <= {shreg[6:0], 1'b0};
                                bit_cnt <= 4'd1;
                                state   <= ST_READ;
                            end
                        end else if (scl_fall) begin
                            sda_low <= 1'b0;
                            bit_cnt <= '0;
                            state   <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shreg   <= byte_in;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                rx_data_q  <= byte_in;
                                rx_valid_q <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_low <= 1'b1;
                            state   <= ST_WR_ACK;
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            sda_low <= 1'b0;
                            bit_cnt <= '0;
                            state   <= ST_WRITE;
                        end
                    end
                    ST_READ: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_low <= 1'b0;
                                bit_cnt <= '0;
                                state   <= ST_RD_ACK;
                            end else begin
                                sda_low <= ~shreg[7];
                                shreg   <= {shreg[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise && bit_cnt == 4'd0) begin
                            if (sda_lvl == I2C_ACK) begin
                                tx_req_q <= 1'b1;
                                bit_cnt  <= CNT_ACKED;
                            end else begin
                                busy_q <= 1'b0;
                                state  <= ST_WAIT_STOP;
                            end
                        end else if (tx_req_q) begin
                            shreg <= usr.tx_data;
                        end else if (scl_fall && bit_cnt == CNT_ACKED) begin
                            sda_low <= ~shreg[7];
                            shreg   <= {shreg[6:0], 1'b0};
                            bit_cnt <= 4'd1;
                            state   <= ST_READ;
                        end
                    end
                    default: begin
                        // IDLE and WAIT_STOP only react to START/STOP.
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: acts as the bus controller and checks the target
// against a byte-level model of the expected bus traffic.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam logic [6:0] TGT = 7'h42;

  // ---------------- clock / reset / bus ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_o = 1'b1;
  logic sda_o_low = 1'b0;
  wire  sda;

  pullup (sda);
  assign sda = sda_o_low ? 1'b0 : 1'bz;

  i2c_target_if usr ();

  i2c_target #(.TARGET_ADDR(TGT), .FILTER_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .I2C_SCL(scl_o), .I2C_SDA_t(sda), .usr(usr)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int n_rx = 0;
  int n_rx_exp = 0;
  int n_tx = 0;
  int n_sda_bad = 0;
  int hp = 5000;
  logic [7:0] exp_q[$];
  logic prev_sda = 1'b1;
  logic prev_scl = 1'b1;
  logic prev_ctrl = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor and SDA-while-SCL-high watch.
  always @(negedge clk) begin
    if (rst_n) begin
      if (usr.rx_valid) begin
        n_rx++;
        check("rx_q_avail", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("rx_data", usr.rx_data, exp_q.pop_front());
      end
      if (usr.tx_req) n_tx++;
      if (usr.rx_valid || usr.tx_req) check("rx_tx_excl", usr.rx_valid && usr.tx_req, 0);
      if (scl_o && prev_scl && (sda !== prev_sda) && (sda_o_low == prev_ctrl)) n_sda_bad++;
    end
    prev_sda  = sda;
    prev_scl  = scl_o;
    prev_ctrl = sda_o_low;
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b, input bit glitch);
    sda_o_low = ~b;
    if (glitch) begin
      #(hp/4); scl_o = 1'b1; #20; scl_o = 1'b0; #(hp/4 - 20);
    end else begin
      #(hp/2);
    end
    scl_o = 1'b1; #(hp);
    scl_o = 1'b0; #(hp/2);
  endtask

  task automatic recv_bit(output logic b);
    sda_o_low = 1'b0;
    #(hp/2); scl_o = 1'b1;
    #(hp/2); b = sda;
    #(hp/2); scl_o = 1'b0;
    #(hp/2);
  endtask

  task automatic i2c_start();
    sda_o_low = 1'b0; #(hp/2);
    scl_o = 1'b1;     #(hp/2);
    sda_o_low = 1'b1; #(hp/2);
    scl_o = 1'b0;     #(hp/2);
  endtask

  task automatic i2c_stop();
    sda_o_low = 1'b1; #(hp/2);
    scl_o = 1'b1;     #(hp/2);
    sda_o_low = 1'b0; #(hp/2);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack, input bit glitch);
    for (int i = 7; i >= 0; i--) send_bit(d[i], glitch && (i == 4));
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack, input logic [7:0] next_tx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    usr.tx_data = next_tx;
    send_bit(nack, 1'b0);
  endtask

  // Write transfer; bytes packed MSB-first in 'bytes'.
  task automatic write_xfer(input logic [6:0] addr, input logic [31:0] bytes, input int len,
                            input bit do_stop, input bit glitch);
    logic hit;
    logic ack;
    logic [7:0] b;
    hit = (addr == TGT);
    i2c_start();
    write_byte({addr, 1'b0}, ack, 1'b0);
    check("w_addr_ack", ack, hit ? 0 : 1);
    check("w_busy", usr.busy, hit ? 1 : 0);
    if (hit) check("w_rw", usr.rw, 0);
    for (int k = 0; k < len; k++) begin
      b = bytes[31 - 8*k -: 8];
      if (hit) begin
        exp_q.push_back(b);
        n_rx_exp++;
      end
      write_byte(b, ack, glitch);
      check("w_data_ack", ack, hit ? 0 : 1);
    end
    if (do_stop) begin
      i2c_stop();
      check("w_busy_end", usr.busy, 0);
      check("w_state_end", usr.state, ST_IDLE);
    end
  endtask

  // Read transfer: controller ACKs every byte but the last.
  task automatic read_xfer(input logic [6:0] addr, input logic [31:0] bytes, input int len);
    logic hit;
    logic ack;
    logic [7:0] d;
    int tx0;
    hit = (addr == TGT);
    tx0 = n_tx;
    usr.tx_data = bytes[31:24];
    i2c_start();
    write_byte({addr, 1'b1}, ack, 1'b0);
    check("r_addr_ack", ack, hit ? 0 : 1);
    check("r_busy", usr.busy, hit ? 1 : 0);
    if (hit) begin
      check("r_rw", usr.rw, 1);
      for (int k = 0; k < len; k++) begin
        read_byte(d, (k == len - 1), (k < 3) ? bytes[23 - 8*k -: 8] : 8'h00);
        check("r_byte", d, bytes[31 - 8*k -: 8]);
      end
      check("r_tx_req_cnt", n_tx - tx0, len);
      check("r_sda_released", sda, 1);
      check("r_busy_nack", usr.busy, 0);
    end
    i2c_stop();
    check("r_busy_end", usr.busy, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sda"}, sda, 1);
    check({tag, "_rx_data"}, usr.rx_data, 0);
    check({tag, "_rx_valid"}, usr.rx_valid, 0);
    check({tag, "_tx_req"}, usr.tx_req, 0);
    check({tag, "_rw"}, usr.rw, 0);
    check({tag, "_busy"}, usr.busy, 0);
    check({tag, "_state"}, usr.state, ST_IDLE);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic ack;
    logic [6:0] ra;
    usr.tx_data = 8'h00;
    repeat (5) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_values("post_rst");

    // Write at 100 kHz.
    hp = 5000;
    write_xfer(TGT, 32'hA53C0000, 2, 1'b1, 1'b0);
    check("t1_rx_data", usr.rx_data, 8'h3C);

    // Wrong address: no ACK anywhere, nothing delivered.
    hp = 1240;
    write_xfer(7'h43, 32'h11000000, 1, 1'b1, 1'b0);
    check("t2_rx_cnt", n_rx, n_rx_exp);

    // Read at 400 kHz, ACK then NACK.
    read_xfer(TGT, 32'h817E0000, 2);

    // Write then repeated START into a read.
    write_xfer(TGT, 32'h05000000, 1, 1'b0, 1'b0);
    check("t4_rw_write", usr.rw, 0);
    read_xfer(TGT, 32'hC3000000, 1);
    check("t4_rx_data", usr.rx_data, 8'h05);
    check("t4_rw_read", usr.rw, 1);

    // Short SCL glitch mid-byte must be rejected.
    write_xfer(TGT, 32'h5A000000, 1, 1'b1, 1'b1);
    check("t5_rx_data", usr.rx_data, 8'h5A);

    // Reset while the target is driving a 0 data bit.
    usr.tx_data = 8'h00;
    i2c_start();
    write_byte({TGT, 1'b1}, ack, 1'b0);
    check("t6_addr_ack", ack, 0);
    check("t6_sda_driven", sda, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("t6_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    scl_o = 1'b1;
    #(hp/2);
    write_xfer(TGT, 32'h99000000, 1, 1'b1, 1'b0);

    // Randomized transfers at a faster SCL.
    hp = 320;
    for (int r = 0; r < 8; r++) begin
      ra = ($urandom_range(0, 1) == 1) ? TGT : 7'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1)
        read_xfer(ra, $urandom, $urandom_range(1, 3));
      else
        write_xfer(ra, $urandom, $urandom_range(1, 3), 1'b1, 1'b0);
    end

    repeat (20) @(negedge clk);
    check("end_rx_cnt", n_rx, n_rx_exp);
    check("end_exp_q_empty", exp_q.size(), 0);
    check("end_sda_stable", n_sda_bad, 0);
    check("end_busy", usr.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
